// File: rtl/control_fsm.sv
// Multicycle RISC-V main control FSM.
// Sequences each instruction through FETCH/DECODE and its execute states.
// All control outputs are decoded from the current state, with op, funct3,
// funct7b5 and zero added where a state depends on them.
module control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [2:0] alu_control,
   output logic       illegal_instr,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t  state_q, state_d;
   alu_op_t alu_op;
   logic    pc_update;
   logic    branch;

   // Next-state selection; unused encodings fall back to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_EXECUTER;
               OP_ITYP:      state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Per-state datapath controls; anything not set here stays 0.
   always_comb begin
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
      alu_op        = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            if (!(op inside {OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_JAL, OP_BEQ}))
               illegal_instr = 1'b1;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = ALU_FUNCT;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = ALU_FUNCT;
         end
         S_ALUWB:    reg_write = 1'b1;
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = ALU_SUB;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU operation decode; subtract only for R-type funct3=000 with funct7b5.
   always_comb begin
      alu_control = 3'b000;
      case (alu_op)
         ALU_SUB:   alu_control = 3'b001;
         ALU_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alu_control = 3'b101;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b000;
            endcase
         end
         default:   alu_control = 3'b000;
      endcase
   end

   // Immediate format follows the opcode in every state.
   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   assign pc_write = pc_update | (branch & zero);
   assign state    = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed instructions followed by
// random ones, each compared cycle by cycle against an instruction-level model.
module tb_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;
   int seq_q[$];

   control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
      .alu_control(alu_control), .illegal_instr(illegal_instr), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected state walk for one instruction, starting at FETCH.
   task automatic build_seq(input logic [6:0] o);
      seq_q = {};
      case (o)
         7'b0000011: seq_q = '{0, 1, 2, 3, 4};
         7'b0100011: seq_q = '{0, 1, 2, 5};
         7'b0110011: seq_q = '{0, 1, 6, 7};
         7'b0010011: seq_q = '{0, 1, 8, 7};
         7'b1101111: seq_q = '{0, 1, 9, 7};
         7'b1100011: seq_q = '{0, 1, 10};
         default:    seq_q = '{0, 1};
      endcase
   endtask

   function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'd1 : 3'd0;
         3'b010:  return 3'd5;
         3'b110:  return 3'd3;
         3'b111:  return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b0010011: return 2'b00;
         7'b0100011:             return 2'b01;
         7'b1100011:             return 2'b10;
         7'b1101111:             return 2'b11;
         default:                return 2'b00;
      endcase
   endfunction

   function automatic bit legal(input logic [6:0] o);
      return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
   endfunction

   // Packed control word:
   // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
   //  imm_src, reg_write, alu_control, illegal_instr}
   function automatic logic [16:0] exp_ctrl(input int st, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7, input logic z);
      logic pw = 0, as = 0, mw = 0, iw = 0, rw = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0;
      logic [2:0] ac = 0;
      case (st)
         0:  begin iw = 1; sb = 2'b10; rs = 2'b10; pw = 1; end
         1:  begin sa = 2'b01; sb = 2'b01; ill = !legal(o); end
         2:  begin sa = 2'b10; sb = 2'b01; end
         3:  as = 1;
         4:  begin rs = 2'b01; rw = 1; end
         5:  begin as = 1; mw = 1; end
         6:  begin sa = 2'b10; ac = funct_alu(o, f3, f7); end
         7:  rw = 1;
         8:  begin sa = 2'b10; sb = 2'b01; ac = funct_alu(o, f3, f7); end
         9:  begin sa = 2'b01; sb = 2'b10; pw = 1; end
         10: begin sa = 2'b10; ac = 3'd1; pw = z; end
         default: ;
      endcase
      return {pw, as, mw, iw, rs, sa, sb, imm_of(o), rw, ac, ill};
   endfunction

   function automatic logic [16:0] dut_ctrl();
      return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
              imm_src, reg_write, alu_control, illegal_instr};
   endfunction

   // Run one instruction from FETCH. zmode: 0/1 fixed zero, 2 random per cycle.
   // rst_at: index of the cycle after which reset is asserted, -1 for none.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int zmode, input int rst_at);
      string walk = "";
      build_seq(o);
      for (int k = 0; k < seq_q.size(); k++) begin
         @(negedge clk);
         op = o; funct3 = f3; funct7b5 = f7;
         zero = (zmode == 2) ? 1'($urandom) : zmode[0];
         #1;
         walk = {walk, $sformatf(" %0d", state)};
         check($sformatf("state[%0d] op=%b", k, o), 32'(state), 32'(seq_q[k]));
         check($sformatf("ctrl[st%0d] op=%b", seq_q[k], o), 32'(dut_ctrl()),
               32'(exp_ctrl(seq_q[k], o, f3, f7, zero)));
         if (k == rst_at) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("rst_state", 32'(state), 32'd0);
            check("rst_mem_write", 32'(mem_write), 32'd0);
            check("rst_reg_write", 32'(reg_write), 32'd0);
            check("rst_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, op, funct3, funct7b5, zero)));
            $display("instr op=%b f3=%b f7=%b states:%s reset", o, f3, f7, walk);
            return;
         end
      end
      $display("instr op=%b f3=%b f7=%b states:%s", o, f3, f7, walk);
   endtask

   logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                 7'b0010011, 7'b1101111, 7'b1100011};

   initial begin
      reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_state", 32'(state), 32'd0);
      check("reset_ir_write", 32'(ir_write), 32'd1);
      check("reset_pc_write", 32'(pc_write), 32'd1);
      check("reset_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, op, funct3, funct7b5, zero)));

      // Directed cases
      run_instr(7'b0000011, 3'b010, 1'b0, 0, -1);  // lw
      run_instr(7'b0100011, 3'b010, 1'b0, 0, -1);  // sw
      run_instr(7'b0110011, 3'b000, 1'b1, 0, -1);  // sub
      run_instr(7'b0110011, 3'b000, 1'b0, 0, -1);  // add
      run_instr(7'b0110011, 3'b010, 1'b0, 0, -1);  // slt
      run_instr(7'b0010011, 3'b000, 1'b1, 0, -1);  // addi, funct7b5 ignored
      run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);  // beq taken
      run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);  // beq not taken
      run_instr(7'b1101111, 3'b000, 1'b0, 0, -1);  // jal
      run_instr(7'b1111111, 3'b000, 1'b0, 0, -1);  // illegal
      run_instr(7'b0100011, 3'b010, 1'b0, 0, 3);   // reset in MEMWRITE
      run_instr(7'b0000011, 3'b010, 1'b0, 0, 3);   // reset in MEMREAD

      // Random instructions with occasional mid-instruction reset
      for (int n = 0; n < 200; n++) begin
         logic [6:0] o;
         int rst_at;
         o = ($urandom_range(0, 3) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 5)];
         build_seq(o);
         rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, seq_q.size() - 1) : -1;
         run_instr(o, 3'($urandom), 1'($urandom), 2, rst_at);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
